// File: rtl/game_pkg.sv
// game_pkg: screen constants, enemy-grid defaults and the collision FSM state type
// shared by collision_unit, its interface and its optional BCD score adder.
package game_pkg;

  localparam int H_RES         = 640;
  localparam int V_RES         = 480;
  localparam int BULLET_IDLE_Y = 480;

  localparam int DEF_ROWS     = 3;
  localparam int DEF_COLS     = 8;
  localparam int DEF_ENEMY_W  = 32;
  localparam int DEF_ENEMY_H  = 16;
  localparam int DEF_PITCH_X  = 48;
  localparam int DEF_PITCH_Y  = 32;
  localparam int DEF_BULLET_W = 4;
  localparam int DEF_BULLET_H = 10;
  localparam int DEF_POINTS   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Elaboration-time conversion of a small decimal constant into four packed BCD digits.
  function automatic logic [15:0] to_bcd16(input int unsigned value);
    int unsigned v;
    logic [15:0] bcd;
    v   = (value > 32'd9999) ? 32'd9999 : value;
    bcd = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      bcd[4*d +: 4] = 4'(v % 32'd10);
      v             = v / 32'd10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/collision_unit_if.sv
// collision_unit_if: frame/bullet/formation inputs and hit/alive/score/finish outputs;
// the master modport drives the inputs, the slave modport is the collision_unit side.
interface collision_unit_if
  import game_pkg::*;
#(
  parameter int N_ENEMY = DEF_ROWS * DEF_COLS
);

  logic               frame_tick;
  logic [9:0]         bulletx;
  logic [9:0]         bullety;
  logic [9:0]         formx;
  logic [9:0]         formy;
  logic               col;
  logic [N_ENEMY-1:0] alive;
  logic [15:0]        score;
  logic               finish;

  modport master (
    output frame_tick, bulletx, bullety, formx, formy,
    input  col, alive, score, finish
  );

  modport slave (
    input  frame_tick, bulletx, bullety, formx, formy,
    output col, alive, score, finish
  );

endinterface

// File: rtl/bcd_adder4.sv
// bcd_adder4: adds two 4-digit packed BCD values and saturates at 16'h9999 on overflow.
// Only instantiated by collision_unit when SCORE_BCD_EN is defined.
module bcd_adder4 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic [4:0]  digit_raw_s;
  logic        carry_s;
  logic [15:0] digits_s;

  always_comb begin
    carry_s     = 1'b0;
    digits_s    = 16'h0000;
    digit_raw_s = 5'd0;
    for (int d = 0; d < 4; d++) begin
      digit_raw_s = {1'b0, a_i[4*d +: 4]} + {1'b0, b_i[4*d +: 4]} + {4'd0, carry_s};
      // A digit above nine wraps by adding six; its low nibble is the decimal digit.
      if (digit_raw_s > 5'd9) begin
        digits_s[4*d +: 4] = 4'(digit_raw_s + 5'd6);
        carry_s            = 1'b1;
      end else begin
        digits_s[4*d +: 4] = digit_raw_s[3:0];
        carry_s            = 1'b0;
      end
    end
    if (carry_s) begin
      sum_o = 16'h9999;
    end else begin
      sum_o = digits_s;
    end
  end

endmodule

// File: rtl/collision_unit.sv
// collision_unit: once per frame scans the enemy grid for a bullet hit, kills the lowest
// hit enemy, pulses col, scores, and latches finish. SCORE_BCD_EN selects a BCD score.
module collision_unit
  import game_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int ENEMY_W  = DEF_ENEMY_W,
  parameter int ENEMY_H  = DEF_ENEMY_H,
  parameter int PITCH_X  = DEF_PITCH_X,
  parameter int PITCH_Y  = DEF_PITCH_Y,
  parameter int BULLET_W = DEF_BULLET_W,
  parameter int BULLET_H = DEF_BULLET_H,
  parameter int POINTS   = DEF_POINTS
) (
  input  logic            clk,
  input  logic            reset,
  collision_unit_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  cidx_q, cidx_d;
  logic [9:0]     bx_q, bx_d;
  logic [9:0]     by_q, by_d;
  logic [9:0]     fx_q, fx_d;
  logic [9:0]     fy_q, fy_d;
  logic [N-1:0]   alive_q, alive_d;
  logic [15:0]    score_q, score_d;
  logic           col_q, col_d;
  logic           finish_q, finish_d;

  logic [10:0]    bx_s, by_s, ex_s, ey_s;
  logic [N-1:0]   kill_s;
  logic [N-1:0]   survivors_s;
  logic           hit_s;
  logic           last_s;
  logic           start_s;
  logic [15:0]    score_add_s;

  // Rectangle overlap test for the enemy at the current scan index, all in 11 bits.
  always_comb begin
    bx_s        = {1'b0, bx_q};
    by_s        = {1'b0, by_q};
    ex_s        = {1'b0, fx_q} + (11'(cidx_q) * 11'(PITCH_X));
    ey_s        = {1'b0, fy_q} + (11'(row_q) * 11'(PITCH_Y));
    kill_s      = {{(N-1){1'b0}}, 1'b1} << idx_q;
    survivors_s = alive_q & ~kill_s;
    hit_s       = (|(alive_q & kill_s))
                  && (bx_s < (ex_s + 11'(ENEMY_W)))
                  && ((bx_s + 11'(BULLET_W)) > ex_s)
                  && (by_s < (ey_s + 11'(ENEMY_H)))
                  && ((by_s + 11'(BULLET_H)) > ey_s);
    last_s      = (idx_q == IW'(N - 1));
    start_s     = bus.frame_tick && (bus.bullety < 10'(BULLET_IDLE_Y)) && !finish_q;
  end

`ifdef SCORE_BCD_EN
  localparam logic [15:0] POINTS_BCD = to_bcd16(POINTS);

  bcd_adder4 u_bcd_adder4 (
    .a_i   (score_q),
    .b_i   (POINTS_BCD),
    .sum_o (score_add_s)
  );
`else
  logic [16:0] score_sum_s;

  always_comb begin
    score_sum_s = {1'b0, score_q} + 17'(POINTS);
    if (score_sum_s[16]) begin
      score_add_s = 16'hFFFF;
    end else begin
      score_add_s = score_sum_s[15:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (hit_s) begin
          if (survivors_s == {N{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else if (last_s) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    row_d    = row_q;
    cidx_d   = cidx_q;
    bx_d     = bx_q;
    by_d     = by_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    alive_d  = alive_q;
    score_d  = score_q;
    col_d    = 1'b0;
    finish_d = finish_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          idx_d  = {IW{1'b0}};
          row_d  = {RW{1'b0}};
          cidx_d = {CW{1'b0}};
          bx_d   = bus.bulletx;
          by_d   = bus.bullety;
          fx_d   = bus.formx;
          fy_d   = bus.formy;
        end else begin
          idx_d = idx_q;
        end
      end
      SCAN: begin
        if (hit_s) begin
          alive_d  = survivors_s;
          col_d    = 1'b1;
          score_d  = score_add_s;
          finish_d = (survivors_s == {N{1'b0}});
        end else begin
          // Row/column counters track the index so the enemy origin needs no divide.
          idx_d = idx_q + IW'(1);
          if (cidx_q == CW'(COLS - 1)) begin
            cidx_d = {CW{1'b0}};
            row_d  = row_q + RW'(1);
          end else begin
            cidx_d = cidx_q + CW'(1);
          end
        end
      end
      DONE: finish_d = 1'b1;
      default: col_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= {IW{1'b0}};
      row_q    <= {RW{1'b0}};
      cidx_q   <= {CW{1'b0}};
      bx_q     <= 10'd0;
      by_q     <= 10'd0;
      fx_q     <= 10'd0;
      fy_q     <= 10'd0;
      alive_q  <= {N{1'b1}};
      score_q  <= 16'h0000;
      col_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      row_q    <= row_d;
      cidx_q   <= cidx_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
      alive_q  <= alive_d;
      score_q  <= score_d;
      col_q    <= col_d;
      finish_q <= finish_d;
    end
  end

  assign bus.col    = col_q;
  assign bus.alive  = alive_q;
  assign bus.score  = score_q;
  assign bus.finish = finish_q;

endmodule

// File: tb/tb_collision_unit.sv
// tb_collision_unit: directed plus randomized frames checked against a grid-level
// reference model (array of alive flags, kill count, rectangle overlap in plain ints).
module tb_collision_unit;
  import game_pkg::*;

  localparam int N = DEF_ROWS * DEF_COLS;

  logic clk = 1'b0;
  logic reset;

  collision_unit_if #(.N_ENEMY(N)) bus ();

  collision_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit alive_m [N];
  int kills_m;
  bit finish_m;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) alive_m[i] = 1'b1;
    kills_m  = 0;
    finish_m = 1'b0;
  endfunction

  function automatic logic [N-1:0] exp_alive();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = alive_m[i];
    return v;
  endfunction

  function automatic logic [15:0] exp_score();
    int s;
    s = kills_m * DEF_POINTS;
`ifdef SCORE_BCD_EN
    if (s > 9999) s = 9999;
    return 16'(((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10));
`else
    if (s > 65535) s = 65535;
    return 16'(s);
`endif
  endfunction

  // Lowest-index live enemy whose rectangle overlaps the bullet, or -1.
  function automatic int model_hit(input int bx, input int by, input int fx, input int fy);
    int ex, ey;
    for (int r = 0; r < DEF_ROWS; r++) begin
      for (int c = 0; c < DEF_COLS; c++) begin
        ex = fx + c * DEF_PITCH_X;
        ey = fy + r * DEF_PITCH_Y;
        if (alive_m[r * DEF_COLS + c] && bx < ex + DEF_ENEMY_W && bx + DEF_BULLET_W > ex &&
            by < ey + DEF_ENEMY_H && by + DEF_BULLET_H > ey)
          return r * DEF_COLS + c;
      end
    end
    return -1;
  endfunction

  task automatic run_frame(input int bx, input int by, input int fx, input int fy, input string tag);
    int  hit, last, col_k, n_col, left;
    bit  scanning;
    scanning = (by < BULLET_IDLE_Y) && !finish_m;
    hit      = scanning ? model_hit(bx, by, fx, fy) : -1;
    last     = (hit >= 0) ? hit : N - 1;
    bus.bulletx    = 10'(bx);
    bus.bullety    = 10'(by);
    bus.formx      = 10'(fx);
    bus.formy      = 10'(fy);
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    if (hit >= 0) begin
      alive_m[hit] = 1'b0;
      kills_m++;
      left = 0;
      for (int i = 0; i < N; i++) left += alive_m[i];
      finish_m = (left == 0);
    end
    col_k = -1;
    n_col = 0;
    for (int k = 2; k <= N + 4; k++) begin
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      if (bus.col === 1'b1) begin
        n_col++;
        if (col_k < 0) begin
          col_k = k;
          chk({tag, "_finish_at_col"}, 64'(bus.finish), 64'(finish_m));
        end
      end
      if (scanning) begin
        // Scrambled live inputs must not disturb the latched scan.
        bus.bulletx = 10'($urandom);
        bus.bullety = 10'($urandom_range(0, 479));
        bus.formx   = 10'($urandom);
        bus.formy   = 10'($urandom);
        if (k == 2 && last >= 1) bus.frame_tick = 1'b1;
      end
    end
    bus.frame_tick = 1'b0;
    chk({tag, "_col_pulses"}, 64'(n_col), (hit >= 0) ? 64'd1 : 64'd0);
    if (hit >= 0) chk({tag, "_col_cycle"}, 64'(col_k), 64'(2 + hit));
    chk({tag, "_alive"}, 64'(bus.alive), 64'(exp_alive()));
    chk({tag, "_score"}, 64'(bus.score), 64'(exp_score()));
    chk({tag, "_finish"}, 64'(bus.finish), 64'(finish_m));
  endtask

  initial begin
    int fx, fy, bx, by, tr, tc;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.bulletx    = 10'd0;
    bus.bullety    = 10'd480;
    bus.formx      = 10'd0;
    bus.formy      = 10'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_alive",  64'(bus.alive),  64'(exp_alive()));
    chk("rst_score",  64'(bus.score),  64'd0);
    chk("rst_col",    64'(bus.col),    64'd0);
    chk("rst_finish", 64'(bus.finish), 64'd0);

    run_frame(110, 60, 100, 50, "tp_first");
    run_frame(200, 90, 100, 50, "tp_idx10");
    run_frame(90, 200, 100, 50, "tp_miss");
    run_frame(110, 480, 100, 50, "tp_nobullet");

    for (int n = 0; n < 40; n++) begin
      fx = (n % 5 == 4) ? int'($urandom_range(560, 900)) : int'($urandom_range(0, 560));
      fy = int'($urandom_range(0, 380));
      tr = int'($urandom_range(0, DEF_ROWS - 1));
      tc = int'($urandom_range(0, DEF_COLS - 1));
      bx = fx + tc * DEF_PITCH_X + int'($urandom_range(0, 44)) - 8;
      by = fy + tr * DEF_PITCH_Y + int'($urandom_range(0, 30)) - 12;
      if (bx < 0) bx = 0;
      if (bx > 1023) bx = 1023;
      if (by < 0) by = 0;
      if (n % 6 == 5) by = int'($urandom_range(480, 1023));
      run_frame(bx, by, fx, fy, "rnd");
    end

    // Reset asserted in cycle T+5 of a scan.
    bus.bulletx    = 10'd90;
    bus.bullety    = 10'd200;
    bus.formx      = 10'd100;
    bus.formy      = 10'd50;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("midrst_alive",  64'(bus.alive),  64'(exp_alive()));
    chk("midrst_score",  64'(bus.score),  64'd0);
    chk("midrst_col",    64'(bus.col),    64'd0);
    chk("midrst_finish", 64'(bus.finish), 64'd0);
    reset = 1'b0;
    run_frame(110, 60, 100, 50, "post_rst");

    for (int i = 0; i < N; i++) begin
      run_frame(100 + (i % DEF_COLS) * DEF_PITCH_X + 14, 50 + (i / DEF_COLS) * DEF_PITCH_Y + 3,
                100, 50, "killall");
    end
    chk("killall_finish", 64'(bus.finish), 64'd1);
`ifdef SCORE_BCD_EN
    chk("killall_score", 64'(bus.score), 64'h0240);
`else
    chk("killall_score", 64'(bus.score), 64'd240);
`endif
    run_frame(110, 60, 100, 50, "after_finish");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
